// File: rtl/game_piece_display.sv
// ---------------------------------------------------------------------------
// game_piece_display
//   Per-pixel overlay that flags pixels inside the Player 1 / Player 2 pieces
//   on the 8x8 serpentine board. Board positions are latched once per frame
//   (at pixel (0,0)) so a piece never tears mid-frame. Flags are registered:
//   the flag for (iX,iY) appears one clock after that coordinate.
//
//   Build option: define PIECE_RING_EN to draw each piece as a ring
//   ((RADIUS-3)^2 < d2 <= RADIUS^2) instead of a filled disc (d2 <= RADIUS^2).
//
// Ports:
//   iClk     in   pixel clock
//   iRst     in   asynchronous reset, active-low
//   iX, iY   in   current pixel coordinate (10 bits each)
//   iP1_Pos  in   P1 board position 0..63
//   iP2_Pos  in   P2 board position 0..63
//   oIs_P1   out  pixel lies inside P1 piece (registered)
//   oIs_P2   out  pixel lies inside P2 piece (registered)
// ---------------------------------------------------------------------------
module game_piece_display #(
    parameter int BOARD_X0 = 128,
    parameter int BOARD_Y0 = 48,
    parameter int CELL     = 48,
    parameter int RADIUS   = 10
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [9:0] iX,
    input  logic [9:0] iY,
    input  logic [5:0] iP1_Pos,
    input  logic [5:0] iP2_Pos,
    output logic       oIs_P1,
    output logic       oIs_P2
);

    localparam logic [10:0] X0    = 11'(BOARD_X0);
    localparam logic [10:0] Y0    = 11'(BOARD_Y0);
    localparam logic [10:0] CW    = 11'(CELL);
    localparam logic [10:0] OFF1  = 11'(CELL / 3);
    localparam logic [10:0] OFF2  = 11'(2 * CELL / 3);
    localparam logic [10:0] OFFY  = 11'(CELL / 2);
    localparam logic signed [22:0] R2    = 23'(RADIUS * RADIUS);
    localparam logic signed [22:0] R_IN2 = 23'((RADIUS - 3) * (RADIUS - 3));

    logic [5:0]  p1_pos;
    logic [5:0]  p2_pos;
    logic [10:0] p1_cx, p1_cy, p2_cx, p2_cy;
    logic        hit1, hit2;

    // Serpentine: odd rows (counted from the bottom) run right-to-left.
    function automatic logic [10:0] centre_x(input logic [5:0] pos, input logic [10:0] off);
        logic [2:0] col;
        col = pos[3] ? ~pos[2:0] : pos[2:0];
        return X0 + 11'(col) * CW + off;
    endfunction

    // Board row 0 is at the bottom of the screen: physical row = 7 - r = ~r.
    function automatic logic [10:0] centre_y(input logic [5:0] pos);
        logic [2:0] row;
        row = ~pos[5:3];
        return Y0 + 11'(row) * CW + OFFY;
    endfunction

    function automatic logic in_piece(input logic [9:0] x, input logic [9:0] y,
                                      input logic [10:0] cx, input logic [10:0] cy);
        logic signed [10:0] dx, dy;
        logic signed [22:0] ex, ey, d2;
        // 11-bit wrap-around subtraction reinterpreted as signed gives the
        // exact difference since all operands are below 1024.
        dx = $signed({1'b0, x} - cx);
        dy = $signed({1'b0, y} - cy);
        ex = {{12{dx[10]}}, dx};
        ey = {{12{dy[10]}}, dy};
        d2 = ex * ex + ey * ey;
`ifdef PIECE_RING_EN
        return (d2 > R_IN2) && (d2 <= R2);
`else
        return d2 <= R2;
`endif
    endfunction

    always_comb begin
        p1_cx = centre_x(p1_pos, OFF1);
        p1_cy = centre_y(p1_pos);
        p2_cx = centre_x(p2_pos, OFF2);
        p2_cy = centre_y(p2_pos);
        hit1  = in_piece(iX, iY, p1_cx, p1_cy);
        hit2  = in_piece(iX, iY, p2_cx, p2_cy);
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            p1_pos <= '0;
            p2_pos <= '0;
            oIs_P1 <= 1'b0;
            oIs_P2 <= 1'b0;
        end else begin
            if (iX == '0 && iY == '0) begin
                p1_pos <= iP1_Pos;
                p2_pos <= iP2_Pos;
            end
            oIs_P1 <= hit1;
            oIs_P2 <= hit2;
        end
    end

endmodule

// File: tb/tb_game_piece_display.sv
// ---------------------------------------------------------------------------
// tb_game_piece_display
//   Directed and randomized checks of game_piece_display against an integer
//   geometry model (cell lookup, centre offsets, squared distance).
// ---------------------------------------------------------------------------
module tb_game_piece_display;

    logic       iClk;
    logic       iRst;
    logic [9:0] iX;
    logic [9:0] iY;
    logic [5:0] iP1_Pos;
    logic [5:0] iP2_Pos;
    logic       oIs_P1;
    logic       oIs_P2;

    int checks = 0;
    int errors = 0;

    // Model's view of the positions latched inside the DUT.
    int m_p1 = 0;
    int m_p2 = 0;

    game_piece_display #(
        .BOARD_X0(128),
        .BOARD_Y0(48),
        .CELL(48),
        .RADIUS(10)
    ) dut (
        .iClk(iClk),
        .iRst(iRst),
        .iX(iX),
        .iY(iY),
        .iP1_Pos(iP1_Pos),
        .iP2_Pos(iP2_Pos),
        .oIs_P1(oIs_P1),
        .oIs_P2(oIs_P2)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    function automatic int cen_x(int pos, int off);
        int r, c, col;
        r = pos / 8;
        c = pos % 8;
        col = (r % 2 == 1) ? 7 - c : c;
        return 128 + col * 48 + off;
    endfunction

    function automatic int cen_y(int pos);
        return 48 + (7 - pos / 8) * 48 + 24;
    endfunction

    function automatic logic model_hit(int x, int y, int cx, int cy);
        int d2;
        d2 = (x - cx) * (x - cx) + (y - cy) * (y - cy);
`ifdef PIECE_RING_EN
        return (d2 > 49) && (d2 <= 100);
`else
        return d2 <= 100;
`endif
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Present one pixel for one clock, track the latch, sample after the edge.
    task automatic drive(input int x, input int y);
        iX = 10'(x);
        iY = 10'(y);
        @(posedge iClk);
        if (x == 0 && y == 0) begin
            m_p1 = int'(iP1_Pos);
            m_p2 = int'(iP2_Pos);
        end
        #1;
    endtask

    task automatic px(input string tag, input int x, input int y, input logic e1, input logic e2);
        drive(x, y);
        chk({tag, "_p1"}, oIs_P1, e1);
        chk({tag, "_p2"}, oIs_P2, e2);
    endtask

    task automatic pxm(input int x, input int y);
        logic e1, e2;
        // Expected values use the positions latched before this edge.
        e1 = model_hit(x, y, cen_x(m_p1, 16), cen_y(m_p1));
        e2 = model_hit(x, y, cen_x(m_p2, 32), cen_y(m_p2));
        if (x == 0 && y == 0) begin
            e1 = 1'b0;
            e2 = 1'b0;
        end
        drive(x, y);
        chk($sformatf("rnd_p1_%0d_%0d_pos%0d", x, y, m_p1), oIs_P1, e1);
        chk($sformatf("rnd_p2_%0d_%0d_pos%0d", x, y, m_p2), oIs_P2, e2);
    endtask

    task automatic latch(input int p1, input int p2);
        iP1_Pos = 6'(p1);
        iP2_Pos = 6'(p2);
        drive(0, 0);
    endtask

    logic disc;

    initial begin
`ifdef PIECE_RING_EN
        disc = 1'b0;
`else
        disc = 1'b1;
`endif
        iRst = 1'b0;
        iX = 10'd144;
        iY = 10'd408;
        iP1_Pos = 6'd0;
        iP2_Pos = 6'd0;
        repeat (3) @(posedge iClk);
        #1;
        chk("reset_p1", oIs_P1, 1'b0);
        chk("reset_p2", oIs_P2, 1'b0);
        @(negedge iClk);
        iRst = 1'b1;

        // Frame origin with both pieces at position 0: centres (144,408), (160,408).
        latch(0, 0);
        px("p1_centre", 144, 408, disc, 1'b0);
        px("p1_d2_64", 144, 416, 1'b1, 1'b0);
        px("p1_d2_100", 144, 418, 1'b1, 1'b0);
        px("p1_d2_121", 144, 419, 1'b0, 1'b0);
        px("far_pixel", 100, 100, 1'b0, 1'b0);
        px("p2_pos0", 160, 416, 1'b0, 1'b1);
        px("blanking", 700, 500, 1'b0, 1'b0);

        // P2 at position 9: cell origin (416,336), centre (448,360).
        latch(0, 9);
        px("p2_pos9_centre", 448, 360, 1'b0, disc);
        px("p2_pos9_d2_64", 448, 352, 1'b0, 1'b1);
        // P2 at position 63: centre (160,72).
        latch(0, 63);
        px("p2_pos63_centre", 160, 72, 1'b0, disc);
        px("p2_pos63_d2_64", 160, 80, 1'b0, 1'b1);

        // Shared cell 20: origin (320,288); centres (336,312) and (352,312).
        latch(20, 20);
        px("shared_p1", 336, 312, disc, 1'b0);
        px("shared_p2", 352, 312, 1'b0, disc);
        px("shared_mid", 344, 312, 1'b1, 1'b1);

        // Mid-frame position change must wait for the next (0,0).
        latch(0, 63);
        iP1_Pos = 6'd5;
        px("hold_old_cell", 144, 416, 1'b1, 1'b0);
        px("hold_new_cell", 384, 416, 1'b0, 1'b0);
        drive(0, 0);
        px("moved_old_cell", 144, 416, 1'b0, 1'b0);
        px("moved_new_cell", 384, 416, 1'b1, 1'b0);

        // Asynchronous reset clears outputs with no clock edge.
        px("pre_async_rst", 384, 416, 1'b1, 1'b0);
        iRst = 1'b0;
        #2;
        chk("async_rst_p1", oIs_P1, 1'b0);
        chk("async_rst_p2", oIs_P2, 1'b0);
        m_p1 = 0;
        m_p2 = 0;
        @(negedge iClk);
        iRst = 1'b1;
        iP1_Pos = 6'd5;
        iP2_Pos = 6'd40;
        px("rst_clears_latch", 144, 416, 1'b1, 1'b0);

        // Randomized frames: pixels biased toward both centres, with stray
        // mid-frame input changes the DUT must ignore.
        for (int f = 0; f < 8; f++) begin
            latch(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
            for (int n = 0; n < 60; n++) begin
                int sel, x, y;
                sel = int'($urandom_range(0, 3));
                if (sel == 0 || sel == 1) begin
                    x = cen_x(m_p1, 16) + int'($urandom_range(0, 24)) - 12;
                    y = cen_y(m_p1) + int'($urandom_range(0, 24)) - 12;
                end else if (sel == 2) begin
                    x = cen_x(m_p2, 32) + int'($urandom_range(0, 24)) - 12;
                    y = cen_y(m_p2) + int'($urandom_range(0, 24)) - 12;
                end else begin
                    x = int'($urandom_range(1, 1023));
                    y = int'($urandom_range(1, 1023));
                end
                if ($urandom_range(0, 9) == 0) begin
                    iP1_Pos = 6'($urandom_range(0, 63));
                    iP2_Pos = 6'($urandom_range(0, 63));
                end
                pxm(x, y);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
